div_iter: RTL and testbench

Iterative radix-2 restoring divider for the execute stage. It is the counterpart to the 64-bit carry-lookahead adder that feeds the HI/LO multiply-accumulate path. It serves MIPS `DIV`/`DIVU` by producing a quotient and remainder over WIDTH+3 clock cycles. The result is packed as {remainder, quotient} so that it writes HI/LO directly. The pipeline stalls on BUSY and captures RESULT on VALID; there is no backpressure.

---
 rtl/div_iter.sv | 157 +++++++++++++++
 tb/tb_div_iter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider serving MIPS DIV/DIVU.
// Produces {remainder, quotient} over WIDTH+3 cycles; result feeds HI/LO.
//
// Ports:
//   CLK       rising-edge clock
//   RESETN    synchronous reset, active-low
//   START     request, sampled only in IDLE
//   SIGNED    1 = DIV (two's complement), 0 = DIVU; sampled with START
//   CANCEL    synchronous abort back to IDLE (exception / flush)
//   DIVIDEND  dividend, sampled with START
//   DIVISOR   divisor, sampled with START
//   BUSY      high in PREP, CALC and FIX
//   VALID     one-cycle pulse in DONE
//   RESULT    {REMAINDER, QUOTIENT}, held until the next completed operation
//
// Configuration macro: DIV_ZERO_FAST_EN
//   defined   - a zero divisor skips CALC (PREP -> FIX), latency 3
//   undefined - a zero divisor runs the full CALC sequence, latency WIDTH+3
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic                 SIGNED,
  input  logic                 CANCEL,
  input  logic [WIDTH-1:0]     DIVIDEND,
  input  logic [WIDTH-1:0]     DIVISOR,
  output logic                 BUSY,
  output logic                 VALID,
  output logic [2*WIDTH-1:0]   RESULT
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             signed_q;
  logic             zero_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic [WIDTH-1:0] orig_q;   // dividend as sampled, for the divide-by-zero remainder
  logic [WIDTH-1:0] dvs_q;    // divisor, then its magnitude
  logic [WIDTH-1:0] quo_q;    // dividend magnitude shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [RES_W-1:0] result_d;

  // One restoring step plus final sign correction
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    quo_fix   = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
    rem_fix   = (signed_q && dvd_neg_q) ? -rem_q : rem_q;
    // Divide by zero bypasses sign correction entirely
    result_d  = zero_q ? {orig_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
  end

  // Next-state logic; CANCEL overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_PREP;
      S_PREP: begin
`ifdef DIV_ZERO_FAST_EN
        state_d = zero_q ? S_FIX : S_CALC;
`else
        state_d = S_CALC;
`endif
      end
      S_CALC: if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (CANCEL) state_d = S_IDLE;
  end

  // State register and registered status outputs
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      BUSY    <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      state_q <= state_d;
      BUSY    <= (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
      VALID   <= (state_d == S_DONE);
    end
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      signed_q  <= 1'b0;
      zero_q    <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      orig_q    <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      RESULT    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START && !CANCEL) begin
            signed_q  <= SIGNED;
            zero_q    <= (DIVISOR == '0);
            dvd_neg_q <= DIVIDEND[WIDTH-1];
            dvs_neg_q <= DIVISOR[WIDTH-1];
            orig_q    <= DIVIDEND;
            dvs_q     <= DIVISOR;
          end
        end
        S_PREP: begin
          quo_q <= (signed_q && dvd_neg_q) ? -orig_q : orig_q;
          dvs_q <= (signed_q && dvs_neg_q) ? -dvs_q : dvs_q;
          rem_q <= '0;
          cnt_q <= '0;
        end
        S_CALC: begin
          // Non-negative trial difference means the divisor fits: keep it, quotient bit 1
          if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          if (!CANCEL) RESULT <= result_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors with a scoreboard queue; a monitor pops and
// compares result and latency on every VALID pulse.
module tb_div_iter;

  localparam int unsigned W = 32;
  localparam int LAT = 35;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 3;
`else
  localparam int ZLAT = 35;
`endif

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic        CANCEL = 1'b0;
  logic [31:0] DIVIDEND = '0;
  logic [31:0] DIVISOR = '0;
  logic        BUSY;
  logic        VALID;
  logic [63:0] RESULT;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          start;
    int          id;
  } exp_t;

  exp_t exp_q[$];

  div_iter #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .START(START),
    .SIGNED(SIGNED),
    .CANCEL(CANCEL),
    .DIVIDEND(DIVIDEND),
    .DIVISOR(DIVISOR),
    .BUSY(BUSY),
    .VALID(VALID),
    .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every VALID must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (RESETN && VALID) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(VALID), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("result_%0d", e.id), RESULT, e.res);
        chk($sformatf("latency_%0d", e.id), 64'(cyc - e.start), 64'(e.lat));
      end
    end
  end

  // Issue one operation, wait (bounded) for VALID, count BUSY cycles
  task automatic run_op(input int id, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int lat, input bit poke);
    int busy_n = 0;
    bit seen = 0;
    exp_q.push_back('{res: exp, lat: lat, start: cyc, id: id});
    START = 1'b1;
    SIGNED = sg;
    DIVIDEND = a;
    DIVISOR = b;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge CLK);
      START = 1'b0;
      if (poke && n == 5) begin
        START = 1'b1;
        SIGNED = ~sg;
        DIVIDEND = 32'd1000;
        DIVISOR = 32'd3;
      end
      if (BUSY) busy_n++;
      if (VALID) seen = 1'b1;
    end
    START = 1'b0;
    chk($sformatf("done_%0d", id), 64'(seen), 64'd1);
    chk($sformatf("busy_cycles_%0d", id), 64'(busy_n), 64'(lat - 1));
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_valid", 64'(VALID), 64'd0);
    chk("rst_result", RESULT, 64'd0);
    RESETN = 1'b1;
    @(negedge CLK);

    run_op(1,  1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, LAT,  1'b0);
    run_op(2,  1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, LAT,  1'b0);
    run_op(3,  1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, LAT,  1'b0);
    run_op(4,  1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, LAT,  1'b0);
    run_op(5,  1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, LAT,  1'b0);
    run_op(6,  1'b1, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF, ZLAT, 1'b0);
    run_op(7,  1'b0, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF, ZLAT, 1'b0);
    run_op(8,  1'b1, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, ZLAT, 1'b0);
    run_op(9,  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, LAT,  1'b0);
    run_op(10, 1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, LAT,  1'b0);

    // CANCEL together with START in IDLE drops the request
    START = 1'b1;
    CANCEL = 1'b1;
    DIVIDEND = 32'd5;
    DIVISOR = 32'd1;
    @(negedge CLK);
    START = 1'b0;
    CANCEL = 1'b0;
    chk("cancel_start_idle_busy", 64'(BUSY), 64'd0);
    repeat (2) @(negedge CLK);

    // CANCEL mid-operation: no VALID, RESULT keeps the previous value
    START = 1'b1;
    SIGNED = 1'b0;
    DIVIDEND = 32'd100;
    DIVISOR = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    chk("cancel_busy_before", 64'(BUSY), 64'd1);
    CANCEL = 1'b1;
    @(negedge CLK);
    CANCEL = 1'b0;
    chk("cancel_busy_after", 64'(BUSY), 64'd0);
    chk("cancel_valid_after", 64'(VALID), 64'd0);
    chk("cancel_result_hold", RESULT, 64'h00000000_FFFFFFFF);
    repeat (40) @(negedge CLK);
    chk("cancel_result_hold_late", RESULT, 64'h00000000_FFFFFFFF);

    // New op after cancel, with a START poke while busy that must be ignored
    run_op(11, 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, LAT, 1'b1);

    // Reset during CALC
    START = 1'b1;
    SIGNED = 1'b0;
    DIVIDEND = 32'd100;
    DIVISOR = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", 64'(BUSY), 64'd0);
    chk("midrst_valid", 64'(VALID), 64'd0);
    chk("midrst_result", RESULT, 64'd0);
    RESETN = 1'b1;
    @(negedge CLK);

    run_op(12, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, LAT, 1'b0);

    repeat (5) @(negedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
